// File: rtl/modadd_ctrl.sv
// Modular add/sub sequencer: drives a multi-precision adder twice, once for the raw
// result and once for the correction by M. Optional watchdog: define MODADD_TIMEOUT_EN.
module modadd_ctrl #(
  parameter int unsigned WIDTH = 514
`ifdef MODADD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
`ifdef MODADD_TIMEOUT_EN
  output logic             err,
`endif
  output logic             add_start,
  output logic             add_subtract,
  output logic             add_shift,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue1,
    StWait1,
    StIssue2,
    StWait2,
    StFinish
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] m_lat;
  logic             sub_lat;
  logic [WIDTH:0]   r_val;
  logic             wait_first;
  logic             accept;
  logic             timed_out;

`ifdef MODADD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] tcnt;
`endif

  assign add_shift = 1'b0;
  assign busy      = (state != StIdle);

  // The adder clears its previous done only after seeing start, so skip the first wait cycle.
  assign accept = add_done && !wait_first;

  always_comb begin
    timed_out = 1'b0;
`ifdef MODADD_TIMEOUT_EN
    timed_out = (tcnt == CntW'(TIMEOUT - 1));
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= StIdle;
      result       <= '0;
      done         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
      m_lat        <= '0;
      sub_lat      <= 1'b0;
      r_val        <= '0;
      wait_first   <= 1'b0;
`ifdef MODADD_TIMEOUT_EN
      err          <= 1'b0;
      tcnt         <= '0;
`endif
    end else begin
      done      <= 1'b0;
      add_start <= 1'b0;
`ifdef MODADD_TIMEOUT_EN
      err       <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (start) begin
            m_lat        <= in_m;
            sub_lat      <= sub;
            add_in_a     <= in_a;
            add_in_b     <= in_b;
            add_subtract <= sub;
            add_start    <= 1'b1;
            state        <= StIssue1;
          end
        end
        StIssue1, StIssue2: begin
          wait_first <= 1'b1;
`ifdef MODADD_TIMEOUT_EN
          tcnt       <= '0;
`endif
          state      <= (state == StIssue1) ? StWait1 : StWait2;
        end
        StWait1: begin
          wait_first <= 1'b0;
`ifdef MODADD_TIMEOUT_EN
          tcnt       <= tcnt + 1'b1;
`endif
          if (accept) begin
            r_val        <= add_result;
            add_in_a     <= add_result[WIDTH-1:0];
            add_in_b     <= m_lat;
            add_subtract <= ~sub_lat;
            add_start    <= 1'b1;
            state        <= StIssue2;
          end else if (timed_out) begin
`ifdef MODADD_TIMEOUT_EN
            err   <= 1'b1;
`endif
            state <= StIdle;
          end
        end
        StWait2: begin
          wait_first <= 1'b0;
`ifdef MODADD_TIMEOUT_EN
          tcnt       <= tcnt + 1'b1;
`endif
          if (accept) begin
            // add: a negative r-M keeps r; sub: a negative a-b takes r+M.
            if (!sub_lat) begin
              result <= add_result[WIDTH] ? r_val[WIDTH-1:0] : add_result[WIDTH-1:0];
            end else begin
              result <= r_val[WIDTH] ? add_result[WIDTH-1:0] : r_val[WIDTH-1:0];
            end
            done  <= 1'b1;
            state <= StFinish;
          end else if (timed_out) begin
`ifdef MODADD_TIMEOUT_EN
            err   <= 1'b1;
`endif
            state <= StIdle;
          end
        end
        StFinish: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modadd_ctrl.sv
// Bench for modadd_ctrl: behavioural adder that holds done until one cycle after the next
// start, plus a scoreboard of expected modular results popped on each done pulse.
module tb_modadd_ctrl;

  localparam int unsigned W = 514;
  localparam int unsigned Lat = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] in_m = '0;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         add_start;
  logic         add_subtract;
  logic         add_shift;
  logic [W-1:0] add_in_a;
  logic [W-1:0] add_in_b;
  logic [W:0]   add_result;
  logic         add_done;
`ifdef MODADD_TIMEOUT_EN
  logic         err;
`endif

  modadd_ctrl #(
    .WIDTH(W)
`ifdef MODADD_TIMEOUT_EN
    ,
    .TIMEOUT(64)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .sub(sub),
    .in_a(in_a),
    .in_b(in_b),
    .in_m(in_m),
    .result(result),
    .done(done),
    .busy(busy),
`ifdef MODADD_TIMEOUT_EN
    .err(err),
`endif
    .add_start(add_start),
    .add_subtract(add_subtract),
    .add_shift(add_shift),
    .add_in_a(add_in_a),
    .add_in_b(add_in_b),
    .add_result(add_result),
    .add_done(add_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  logic never_done = 1'b0;
  logic [W-1:0] exp_q[$];

  // Adder model: result computed at start, done raised Lat cycles later and held; the old
  // done is only cleared one cycle after start, so it is stale in the first wait cycle.
  logic [3:0] acnt;
  logic       pend;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      add_done   <= 1'b0;
      add_result <= '0;
      acnt       <= '0;
      pend       <= 1'b0;
    end else begin
      pend <= add_start;
      if (add_start) begin
        add_result <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                   : ({1'b0, add_in_a} + {1'b0, add_in_b});
        acnt <= 4'(Lat);
      end else if (acnt != 0) begin
        acnt <= acnt - 1'b1;
      end
      if (pend) add_done <= 1'b0;
      else if (acnt == 4'd1 && !never_done) add_done <= 1'b1;
    end
  end

  function automatic logic [W-1:0] mod_ref(input logic s, input logic [W-1:0] a, b, m);
    logic [W+1:0] t;
    if (!s) begin
      t = {2'b0, a} + {2'b0, b};
      if (t >= {2'b0, m}) t = t - {2'b0, m};
    end else if (a >= b) begin
      t = {2'b0, a} - {2'b0, b};
    end else begin
      t = {2'b0, a} + {2'b0, m} - {2'b0, b};
    end
    return t[W-1:0];
  endfunction

  // Output monitor: scoreboard pops, pulse widths, operand stability during waits.
  logic         prev_start = 1'b0;
  logic         prev_done = 1'b0;
  logic         watch = 1'b0;
  logic         watch_first = 1'b0;
  logic [W-1:0] cap_a;
  logic [W-1:0] cap_b;
  logic         cap_s;
  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: result=%0h with no pending operation", result);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (result !== e) begin
            n_fail++;
            $display("FAIL result: got %0h expected %0h", result, e);
          end
        end
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL done_width: done high %0d cycles, expected 1", 2);
        end
      end
      if (add_start) begin
        start_cnt++;
        n_checks++;
        if (prev_start) begin
          n_fail++;
          $display("FAIL add_start_width: high %0d cycles, expected 1", 2);
        end
      end
      if (watch) begin
        n_checks++;
        if (add_in_a !== cap_a || add_in_b !== cap_b || add_subtract !== cap_s) begin
          n_fail++;
          $display("FAIL operand_stable: a=%0h b=%0h s=%0b expected a=%0h b=%0h s=%0b",
                   add_in_a, add_in_b, add_subtract, cap_a, cap_b, cap_s);
        end
      end
      if (add_start) begin
        cap_a = add_in_a;
        cap_b = add_in_b;
        cap_s = add_subtract;
        watch = 1'b1;
        watch_first = 1'b1;
      end else if (watch && watch_first) begin
        watch_first = 1'b0;
      end else if (watch && add_done) begin
        watch = 1'b0;
      end
      prev_start = add_start;
      prev_done  = done;
    end else begin
      watch = 1'b0;
      prev_start = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic drive(input logic s, input logic [W-1:0] a, b, m);
    @(posedge clk);
    #1;
    start = 1'b1;
    sub   = s;
    in_a  = a;
    in_b  = b;
    in_m  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic s, input logic [W-1:0] a, b, m);
    exp_q.push_back(mod_ref(s, a, b, m));
    drive(s, a, b, m);
  endtask

  task automatic wait_done(input string name);
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    n_checks++;
    if (done_cnt == n0) begin
      n_fail++;
      $display("FAIL %s_timeout: done count %0d, expected %0d", name, done_cnt, n0 + 1);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || add_start !== 1'b0 ||
        add_subtract !== 1'b0 || add_in_a !== '0 || add_in_b !== '0 || add_shift !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: result=%0h done=%0b busy=%0b add_start=%0b sub=%0b a=%0h b=%0h, want 0",
               name, result, done, busy, add_start, add_subtract, add_in_a, add_in_b);
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_zero("reset_asserted");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_idle_zero("reset_released");
  endtask

  task automatic test_add();
    int s0;
    int d0;
    s0 = start_cnt;
    d0 = done_cnt;
    issue(1'b0, W'(7), W'(9), W'(13));
    wait_done("add_7_9");
    n_checks++;
    if (start_cnt - s0 != 2 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL add_pulses: add_start %0d done %0d, expected 2 and 1",
               start_cnt - s0, done_cnt - d0);
    end
    issue(1'b0, W'(2), W'(3), W'(13));
    wait_done("add_2_3");
  endtask

  task automatic test_sub();
    issue(1'b1, W'(3), W'(5), W'(13));
    wait_done("sub_3_5");
    issue(1'b1, W'(9), W'(4), W'(13));
    wait_done("sub_9_4");
    issue(1'b1, W'(4), W'(4), W'(13));
    wait_done("sub_4_4");
  endtask

  task automatic test_wide();
    logic [W-1:0] m;
    m = '0;
    m[512] = 1'b1;
    m[0] = 1'b1;
    issue(1'b0, m - 1'b1, m - 1'b1, m);
    wait_done("wide_add");
    issue(1'b1, W'(1), m - 1'b1, m);
    wait_done("wide_sub");
  endtask

  task automatic test_back_to_back();
    issue(1'b0, W'(7), W'(9), W'(13));
    wait_done("b2b_add");
    issue(1'b1, W'(3), W'(5), W'(13));
    wait_done("b2b_sub");
  endtask

  task automatic test_busy_start();
    int d0;
    d0 = done_cnt;
    issue(1'b0, W'(11), W'(12), W'(13));
    drive(1'b1, W'(1), W'(2), W'(5));
    wait_done("busy_start");
    repeat (15) @(posedge clk);
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL busy_start_dones: got %0d done pulses, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    drive(1'b0, W'(5), W'(6), W'(13));
    #1;
    start = 1'b1;
    in_a = W'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_idle_zero("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: dones %0d busy %0b, expected 0 and 0", done_cnt - d0, busy);
    end
    issue(1'b0, W'(1), W'(1), W'(13));
    wait_done("after_reset");
  endtask

`ifdef MODADD_TIMEOUT_EN
  task automatic test_timeout();
    int d0;
    int waits;
    int k;
    logic [W-1:0] r0;
    logic seen;
    d0 = done_cnt;
    r0 = result;
    never_done = 1'b1;
    drive(1'b0, W'(4), W'(5), W'(13));
    waits = 0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (err) seen = 1'b1;
      else if (busy && !add_start) waits++;
    end
    n_checks++;
    if (!seen || waits != 64 || busy !== 1'b0 || done_cnt != d0 || result !== r0) begin
      n_fail++;
      $display("FAIL timeout: err=%0b waits=%0d busy=%0b dones=%0d result=%0h, want 1 64 0 0 %0h",
               seen, waits, busy, done_cnt - d0, result, r0);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width: err=%0b one cycle later, expected 0", err);
    end
    never_done = 1'b0;
    issue(1'b0, W'(12), W'(12), W'(13));
    wait_done("after_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wide();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
`ifdef MODADD_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
